// File: rtl/uart_rx_if.sv
// ============================================================================
// Module   : uart_rx_if
// Brief    : Serial-in / byte-out bundle between a UART receiver and its user.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 b_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 rx_busy;
  logic                 frame_err;

  // slave = the receiver itself; master = whoever drives the line and tick
  modport slave (
    input  b_tick, rx,
    output rx_data, rx_done, rx_busy, frame_err
  );

  modport master (
    output b_tick, rx,
    input  rx_data, rx_done, rx_busy, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : 16x-oversampled UART deframer (8N1 by default), byte + strobe out.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  uart_rx_if.slave  bus
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;

  localparam logic [TW-1:0] c_tick_mid  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] c_tick_last = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] c_bit_last  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_q,     state_d;
  logic                 rx_meta_q,   rx_meta_d;
  logic                 rx_s_q,      rx_s_d;
  logic [TW-1:0]        tick_cnt_q,  tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q,   bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q,     shreg_d;
  logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
  logic                 rx_done_q,   rx_done_d;
  logic                 frame_err_q, frame_err_d;

  // Synchronizer presets to 1 so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rx_meta_d   = bus.rx;
    rx_s_d      = rx_meta_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end
      end

      // Re-check the line half a bit in to reject glitches.
      S_START: begin
        if (bus.b_tick) begin
          if (tick_cnt_q == c_tick_mid) begin
            if (!rx_s_q) begin
              state_d    = S_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d    = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (bus.b_tick) begin
          if (tick_cnt_q == c_tick_last) begin
            shreg_d    = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == c_bit_last) begin
              state_d   = S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      // Leave at mid-stop so the next start edge can be caught right away.
      S_STOP: begin
        if (bus.b_tick) begin
          if (tick_cnt_q == c_tick_last) begin
            state_d    = S_IDLE;
            tick_cnt_d = '0;
            if (rx_s_q) begin
              rx_data_d = shreg_q;
              rx_done_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy   = (state_q != S_IDLE);

endmodule

`default_nettype wire
